// File: rtl/ap3_fifo_pkg.sv
// Shared constants and helpers for the AP3 RAM FIFO controller.
package ap3_fifo_pkg;

  // Widest supported address is 11 bits, so thresholds fit in 12 bits.
  localparam int unsigned ADDR_W_MAX = 11;
  localparam int unsigned THR_W      = ADDR_W_MAX + 1;

  // Threshold select encoding, shared with the RAM's UPAE/UPAF inputs.
  typedef enum logic [1:0] {
    THR_1 = 2'b00,
    THR_2 = 2'b01,
    THR_4 = 2'b10,
    THR_8 = 2'b11
  } thr_sel_e;

  // Number of RAM entries addressed by an addr_w-bit pointer.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Map a 2-bit threshold select to an entry count.
  function automatic logic [THR_W-1:0] thr_decode(input logic [1:0] sel);
    logic [THR_W-1:0] thr;
    case (thr_sel_e'(sel))
      THR_1:   thr = THR_W'(1);
      THR_2:   thr = THR_W'(2);
      THR_4:   thr = THR_W'(4);
      THR_8:   thr = THR_W'(8);
      default: thr = THR_W'(1);
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/ap3_fifo_ctl.sv
// FIFO controller driving the AP3 dual-port RAM strobes and addresses,
// tracking occupancy and producing level and sticky error flags.
module ap3_fifo_ctl
  import ap3_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [1:0]        ae_sel,
  input  logic [1:0]        af_sel,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              rvalid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              aempty,
  output logic              afull,
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  thr_ae;
  logic [CNT_W-1:0]  thr_af;
  logic              push_ok;
  logic              pop_ok;

  // Accept decisions and level flags, all from the registered count.
  always_comb begin
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    push_ok = push & ~full & ~flush;
    pop_ok  = pop & ~empty & ~flush;
    wen     = push_ok;
    ren     = pop_ok;
    waddr   = wptr;
    raddr   = rptr;
    thr_ae  = CNT_W'(thr_decode(ae_sel));
    thr_af  = CNT_W'(thr_decode(af_sel));
    aempty  = (count <= thr_ae);
    afull   = (count >= (DEPTH_C - thr_af));
  end

  // Pointers, occupancy, read-valid pipeline and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      wptr   <= wptr + ADDR_W'(push_ok);
      rptr   <= rptr + ADDR_W'(pop_ok);
      count  <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      rvalid <= pop_ok;
      ovf    <= ovf | (push & full);
      udf    <= udf | (pop & empty);
    end
  end

endmodule

// File: tb/tb_ap3_fifo_ctl.sv
// Self-checking bench for ap3_fifo_ctl at ADDR_W=4 with a behavioural RAM
// and a data scoreboard on the read side.
module tb_ap3_fifo_ctl;

  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          push;
  logic          pop;
  logic [1:0]    ae_sel;
  logic [1:0]    af_sel;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          ren;
  logic [AW-1:0] raddr;
  logic          rvalid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          aempty;
  logic          afull;
  logic          ovf;
  logic          udf;

  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [15:0] mem [DEPTH];
  logic [15:0] data_ctr;
  logic [15:0] sb_q [$];

  int vectors;
  int miscompares;

  int   m_count;
  int   m_wptr;
  int   m_rptr;
  logic m_ovf;
  logic m_udf;
  logic m_rvalid;

  ap3_fifo_ctl #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .push   (push),
    .pop    (pop),
    .ae_sel (ae_sel),
    .af_sel (af_sel),
    .wen    (wen),
    .waddr  (waddr),
    .ren    (ren),
    .raddr  (raddr),
    .rvalid (rvalid),
    .count  (count),
    .empty  (empty),
    .full   (full),
    .aempty (aempty),
    .afull  (afull),
    .ovf    (ovf),
    .udf    (udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

  task automatic model_reset();
    m_count  = 0;
    m_wptr   = 0;
    m_rptr   = 0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_rvalid = 1'b0;
    sb_q.delete();
  endtask

  task automatic set_inputs(input logic p, input logic q, input logic f);
    push  = p;
    pop   = q;
    flush = f;
    wdata = data_ctr;
  endtask

  // Advance one clock, update the model, then check the read side.
  task automatic clock_edge();
    logic p_ok;
    logic q_ok;
    logic [15:0] exp_d;
    @(posedge clk);
    p_ok = push && (m_count != DEPTH) && !flush;
    q_ok = pop && (m_count != 0) && !flush;
    if (flush) begin
      model_reset();
    end else begin
      if (p_ok) begin
        sb_q.push_back(wdata);
        data_ctr = data_ctr + 16'd1;
      end
      if (push && m_count == DEPTH) m_ovf = 1'b1;
      if (pop && m_count == 0) m_udf = 1'b1;
      m_wptr   = (m_wptr + int'(p_ok)) % DEPTH;
      m_rptr   = (m_rptr + int'(q_ok)) % DEPTH;
      m_count  = m_count + int'(p_ok) - int'(q_ok);
      m_rvalid = q_ok;
    end
    @(negedge clk);
    vectors++;
    if (rvalid !== m_rvalid) begin
      miscompares++;
      $display("FAIL rvalid: got %b expected %b at %0t", rvalid, m_rvalid, $time);
    end
    if (m_rvalid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underrun: read expected but scoreboard empty at %0t", $time);
      end else begin
        exp_d = sb_q.pop_front();
        if (rdata !== exp_d) begin
          miscompares++;
          $display("FAIL rdata: got %h expected %h at %0t", rdata, exp_d, $time);
        end
      end
    end
  endtask

  task automatic idle_push(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b1, 1'b0, 1'b0);
      clock_edge();
    end
  endtask

  task automatic idle_pop(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b0, 1'b1, 1'b0);
      clock_edge();
    end
  endtask

  task automatic do_flush();
    set_inputs(1'b0, 1'b0, 1'b1);
    clock_edge();
    set_inputs(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    vectors++;
    if ({count, empty, full, aempty, afull, wen, ren, rvalid, ovf, udf, waddr, raddr}
        !== {5'd0, 4'b1010, 5'b00000, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b wen=%b ren=%b rv=%b ovf=%b udf=%b wa=%0d ra=%0d",
               count, empty, full, aempty, afull, wen, ren, rvalid, ovf, udf, waddr, raddr);
    end
    model_reset();
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0);
    clock_edge();
    idle_push(3);
    idle_pop(1);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({count, empty, full, aempty, afull, wen, ren, rvalid, ovf, udf, waddr, raddr}
        !== {5'd0, 4'b1010, 5'b00000, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL midstream_reset: got cnt=%0d rv=%b wa=%0d ra=%0d ren=%b",
               count, rvalid, waddr, raddr, ren);
    end
    model_reset();
    #1 rst = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0);
    clock_edge();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      set_inputs(1'b1, 1'b0, 1'b0);
      af_sel = 2'b00;
      #1;
      vectors++;
      if (wen !== 1'b1 || waddr !== 4'(i)) begin
        miscompares++;
        $display("FAIL fill_wen: i=%0d wen=%b waddr=%0d expected 1/%0d", i, wen, waddr, i);
      end
      vectors++;
      if (afull !== (i >= 15)) begin
        miscompares++;
        $display("FAIL afull_sel00: count=%0d got %b expected %b", i, afull, (i >= 15));
      end
      af_sel = 2'b11;
      #1;
      vectors++;
      if (afull !== (i >= 8)) begin
        miscompares++;
        $display("FAIL afull_sel11: count=%0d got %b expected %b", i, afull, (i >= 8));
      end
      clock_edge();
      vectors++;
      if (count !== 5'(i + 1) || full !== (i == 15)) begin
        miscompares++;
        $display("FAIL fill_count: got %0d full=%b expected %0d full=%b", count, full, i + 1, (i == 15));
      end
    end
    af_sel = 2'b00;
    set_inputs(1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (wen !== 1'b0) begin
      miscompares++;
      $display("FAIL push_full_wen: got %b expected 0", wen);
    end
    clock_edge();
    vectors++;
    if ({count, ovf, full} !== {5'd16, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL overflow: got cnt=%0d ovf=%b full=%b expected 16/1/1", count, ovf, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      set_inputs(1'b0, 1'b1, 1'b0);
      #1;
      vectors++;
      if (ren !== 1'b1 || raddr !== 4'(i)) begin
        miscompares++;
        $display("FAIL drain_ren: i=%0d ren=%b raddr=%0d expected 1/%0d", i, ren, raddr, i);
      end
      clock_edge();
    end
    vectors++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL drain_empty: got empty=%b cnt=%0d expected 1/0", empty, count);
    end
    set_inputs(1'b0, 1'b1, 1'b0);
    #1;
    vectors++;
    if (ren !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_empty_ren: got %b expected 0", ren);
    end
    clock_edge();
    vectors++;
    if (udf !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow: got udf=%b expected 1", udf);
    end
  endtask

  task automatic test_back_to_back();
    logic e_wen;
    logic e_ren;
    do_flush();
    idle_push(16);
    for (int i = 0; i < 20; i++) begin
      set_inputs(1'b1, 1'b1, 1'b0);
      e_wen = (m_count != DEPTH);
      e_ren = (m_count != 0);
      #1;
      vectors++;
      if ({wen, ren, waddr, raddr} !== {e_wen, e_ren, 4'(m_wptr), 4'(m_rptr)}) begin
        miscompares++;
        $display("FAIL b2b_strobes: i=%0d got wen=%b ren=%b wa=%0d ra=%0d expected %b %b %0d %0d",
                 i, wen, ren, waddr, raddr, e_wen, e_ren, m_wptr, m_rptr);
      end
      clock_edge();
      vectors++;
      if (count !== 5'(m_count) || ovf !== m_ovf) begin
        miscompares++;
        $display("FAIL b2b_count: i=%0d got cnt=%0d ovf=%b expected %0d %b", i, count, ovf, m_count, m_ovf);
      end
    end
    for (int k = 0; k < 20 && m_count != 0; k++) idle_pop(1);
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_drained: got empty=%b expected 1", empty);
    end
    set_inputs(1'b1, 1'b1, 1'b0);
    #1;
    vectors++;
    if (wen !== 1'b1 || ren !== 1'b0) begin
      miscompares++;
      $display("FAIL pushpop_empty: got wen=%b ren=%b expected 1/0", wen, ren);
    end
    clock_edge();
    vectors++;
    if (count !== 5'd1 || udf !== 1'b1) begin
      miscompares++;
      $display("FAIL pushpop_empty_after: got cnt=%0d udf=%b expected 1/1", count, udf);
    end
  endtask

  task automatic test_flush();
    do_flush();
    idle_push(17);
    idle_pop(11);
    vectors++;
    if (count !== 5'd5 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup: got cnt=%0d ovf=%b expected 5/1", count, ovf);
    end
    set_inputs(1'b1, 1'b1, 1'b1);
    #1;
    vectors++;
    if (wen !== 1'b0 || ren !== 1'b0 || rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_cycle: got wen=%b ren=%b rvalid=%b expected 0/0/1", wen, ren, rvalid);
    end
    clock_edge();
    vectors++;
    if ({count, waddr, raddr, ovf, empty} !== {5'd0, 4'd0, 4'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_after: got cnt=%0d wa=%0d ra=%0d ovf=%b empty=%b expected 0 0 0 0 1",
               count, waddr, raddr, ovf, empty);
    end
    set_inputs(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ae_sweep();
    logic [3:0] exp_ae;
    exp_ae = 4'b1110;
    do_flush();
    idle_push(2);
    set_inputs(1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      ae_sel = 2'(s);
      #1;
      vectors++;
      if (aempty !== exp_ae[s]) begin
        miscompares++;
        $display("FAIL ae_sweep: sel=%0d count=2 got %b expected %b", s, aempty, exp_ae[s]);
      end
    end
    ae_sel = 2'b00;
    idle_pop(1);
    #1;
    vectors++;
    if (aempty !== 1'b1 || count !== 5'd1) begin
      miscompares++;
      $display("FAIL ae_boundary: count=%0d got %b expected 1", count, aempty);
    end
    clock_edge();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    data_ctr    = 16'h0100;
    rst         = 1'b1;
    ae_sel      = 2'b00;
    af_sel      = 2'b00;
    wdata       = '0;
    set_inputs(1'b0, 1'b0, 1'b0);
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_ae_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
